// File: rtl/video_timing_ctrl.sv
// Raster timing controller: pixel/line counters, active window, sync strobes,
// line/frame pulses and a PIPE_DLY-deep delayed copy of video_on/h_sync/v_sync.
module video_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic        rfr_clk,
  input  logic        reset,
  input  logic        enable,
  output logic [11:0] pixel_cnt,
  output logic [11:0] line_cnt,
  output logic        video_on,
  output logic        h_sync,
  output logic        v_sync,
  output logic        video_on_d,
  output logic        h_sync_d,
  output logic        v_sync_d,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int unsigned CW      = 12;
  localparam int unsigned FW      = 16;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned PW      = (PIPE_DLY == 0) ? 1 : PIPE_DLY;

  // Window bounds are one bit wider so an end bound of 4096 still compares correctly.
  localparam logic [CW:0]   H_ACT_C = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   HS_BEG  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HS_END  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   V_ACT_C = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   VS_BEG  = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VS_END  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

  if (H_TOTAL > 4096) begin : g_bad_h_total
    $error("video_timing_ctrl: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : g_bad_v_total
    $error("video_timing_ctrl: V_TOTAL exceeds 4096");
  end
  if (PIPE_DLY > 4) begin : g_bad_pipe_dly
    $error("video_timing_ctrl: PIPE_DLY must be 0..4");
  end

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_pix, r_line, w_pix_nxt, w_line_nxt;
  logic [FW-1:0]   r_frame, w_frame_nxt;
  logic            r_video_on, r_hs, r_vs, r_ls, r_fs;
  logic            w_run, w_video_on, w_hs, w_vs, w_ls, w_fs;
  logic [CW:0]     w_pix_x, w_line_x;

  // State and output registers
  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pix      <= '0;
      r_line     <= '0;
      r_frame    <= '0;
      r_video_on <= 1'b0;
      r_hs       <= ~HS_POL;
      r_vs       <= ~VS_POL;
      r_ls       <= 1'b0;
      r_fs       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pix      <= w_pix_nxt;
      r_line     <= w_line_nxt;
      r_frame    <= w_frame_nxt;
      r_video_on <= w_video_on;
      r_hs       <= w_hs;
      r_vs       <= w_vs;
      r_ls       <= w_ls;
      r_fs       <= w_fs;
    end
  end

  // Next position, then flags derived from that position so they register together
  always_comb begin
    w_state_nxt = r_state;
    w_pix_nxt   = '0;
    w_line_nxt  = '0;
    w_frame_nxt = r_frame;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_RUN;
          w_run       = 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_run = 1'b1;
          if (r_pix == H_LAST) begin
            if (r_line == V_LAST) begin
              w_frame_nxt = r_frame + FW'(1);
            end else begin
              w_line_nxt = r_line + CW'(1);
            end
          end else begin
            w_pix_nxt  = r_pix + CW'(1);
            w_line_nxt = r_line;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_pix_x    = {1'b0, w_pix_nxt};
    w_line_x   = {1'b0, w_line_nxt};
    w_video_on = w_run && (w_pix_x < H_ACT_C) && (w_line_x < V_ACT_C);
    w_hs       = (w_run && (w_pix_x >= HS_BEG) && (w_pix_x < HS_END)) ? HS_POL : ~HS_POL;
    w_vs       = (w_run && (w_line_x >= VS_BEG) && (w_line_x < VS_END)) ? VS_POL : ~VS_POL;
    w_ls       = w_run && (w_pix_nxt == '0);
    w_fs       = w_run && (w_pix_nxt == '0) && (w_line_nxt == '0);
  end

  assign pixel_cnt   = r_pix;
  assign line_cnt    = r_line;
  assign frame_cnt   = r_frame;
  assign video_on    = r_video_on;
  assign h_sync      = r_hs;
  assign v_sync      = r_vs;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

  // Delay line keeps shifting in IDLE so inactive levels drain through
  if (PIPE_DLY == 0) begin : g_no_dly
    assign video_on_d = r_video_on;
    assign h_sync_d   = r_hs;
    assign v_sync_d   = r_vs;
  end else begin : g_dly
    logic [PW-1:0] r_vo_pipe, r_hs_pipe, r_vs_pipe;

    always_ff @(posedge rfr_clk) begin
      if (reset) begin
        r_vo_pipe <= '0;
        r_hs_pipe <= {PW{~HS_POL}};
        r_vs_pipe <= {PW{~VS_POL}};
      end else begin
        r_vo_pipe <= PW'({r_vo_pipe, r_video_on});
        r_hs_pipe <= PW'({r_hs_pipe, r_hs});
        r_vs_pipe <= PW'({r_vs_pipe, r_vs});
      end
    end

    assign video_on_d = r_vo_pipe[PW-1];
    assign h_sync_d   = r_hs_pipe[PW-1];
    assign v_sync_d   = r_vs_pipe[PW-1];
  end

endmodule
